// File: rtl/elevador_param.sv
// Parametrised elevator controller: SCAN scheduling, timed door, occupancy limit and emergency descent.
// fsm_state mirrors the internal state (0 IDLE, 1 UP, 2 DOWN, 3 DOOR, 4 EMERG) for observation.
module elevador_param #(
    parameter int N_FLOORS   = 8,
    parameter int MAX_PEOPLE = 7,
    parameter int TICK_DIV   = 100,
    parameter int DOOR_TICKS = 3
) (
    input  logic                            CLOCK_50,
    input  logic                            RST_N,
    input  logic [N_FLOORS-1:0]             call_sw,
    input  logic                            add_p,
    input  logic                            rem_p,
    input  logic                            emerg_p,
    output logic [3:0]                      floor,
    output logic [1:0]                      dir,
    output logic                            door_open,
    output logic [N_FLOORS-1:0]             calls,
    output logic [$clog2(MAX_PEOPLE+1)-1:0] people,
    output logic                            full,
    output logic                            emergency,
    output logic [2:0]                      fsm_state
);
    localparam int FW = 4;
    localparam int PW = $clog2(MAX_PEOPLE + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DOOR_TICKS > 0) ? $clog2(DOOR_TICKS + 1) : 1;
    localparam logic [FW-1:0] TOP  = FW'(N_FLOORS);
    localparam logic [PW-1:0] MAXP = PW'(MAX_PEOPLE);
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DOWN  = 3'd2,
        S_DOOR  = 3'd3,
        S_EMERG = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [FW-1:0]       floor_q, floor_n, nf;
    logic [1:0]          dir_q, dir_n;
    logic [DW-1:0]       door_cnt_q, door_cnt_n;
    logic [TW-1:0]       tick_cnt_q;
    logic [N_FLOORS-1:0] call_sw_q, calls_q, calls_n, clr;
    logic [PW-1:0]       people_q, people_n;
    logic                tick, car_full, in_emerg, resched, up_ok, dn_ok;

    function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FW-1:0] f);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) m[i] = (i + 1 == int'(f));
        return m;
    endfunction

    function automatic logic calls_above(input logic [N_FLOORS-1:0] c, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) if (c[i] && (i + 1 > int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic calls_below(input logic [N_FLOORS-1:0] c, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) if (c[i] && (i + 1 < int'(f))) r = 1'b1;
        return r;
    endfunction

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            floor_q    <= FW'(1);
            dir_q      <= DIR_IDLE;
            door_cnt_q <= '0;
            tick_cnt_q <= '0;
            call_sw_q  <= '0;
            calls_q    <= '0;
            people_q   <= '0;
        end else begin
            state_q    <= state_n;
            floor_q    <= floor_n;
            dir_q      <= dir_n;
            door_cnt_q <= door_cnt_n;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            call_sw_q  <= call_sw;
            calls_q    <= calls_n;
            people_q   <= people_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        floor_n    = floor_q;
        dir_n      = dir_q;
        door_cnt_n = door_cnt_q;
        clr        = '0;
        nf         = floor_q;
        resched    = 1'b0;
        car_full   = (people_q == MAXP);
        in_emerg   = (state_q == S_EMERG);
        up_ok      = calls_above(calls_q, floor_q);
        dn_ok      = calls_below(calls_q, floor_q);

        if (emerg_p && !in_emerg) begin
            state_n = S_EMERG;
            dir_n   = DIR_DOWN;
        end else if (tick) begin
            case (state_q)
                S_IDLE: resched = 1'b1;
                S_UP, S_DOWN: begin
                    // A full car parked mid-shaft simply holds until someone leaves.
                    if (!car_full) begin
                        if (state_q == S_UP) nf = (floor_q < TOP) ? floor_q + FW'(1) : floor_q;
                        else                 nf = (floor_q > FW'(1)) ? floor_q - FW'(1) : floor_q;
                        floor_n = nf;
                        if (|(calls_q & floor_mask(nf))) begin
                            clr        = floor_mask(nf);
                            state_n    = S_DOOR;
                            door_cnt_n = DW'(DOOR_TICKS);
                        end else if ((state_q == S_UP) ? calls_above(calls_q, nf)
                                                       : calls_below(calls_q, nf)) begin
                            state_n = state_q;
                        end else if (calls_q != '0) begin
                            state_n = (state_q == S_UP) ? S_DOWN : S_UP;
                            dir_n   = (state_q == S_UP) ? DIR_DOWN : DIR_UP;
                        end else begin
                            state_n = S_IDLE;
                            dir_n   = DIR_IDLE;
                        end
                    end
                end
                S_DOOR: begin
                    if (door_cnt_q > DW'(1)) door_cnt_n = door_cnt_q - DW'(1);
                    else if (car_full)       door_cnt_n = DW'(DOOR_TICKS);
                    else                     resched    = 1'b1;
                end
                S_EMERG: begin
                    // Descent is not gated by occupancy: people cannot leave during an emergency.
                    if (floor_q > FW'(1)) begin
                        floor_n = floor_q - FW'(1);
                    end else begin
                        state_n    = S_DOOR;
                        door_cnt_n = DW'(DOOR_TICKS);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    dir_n   = DIR_IDLE;
                end
            endcase
        end

        if (resched) begin
            if (|(calls_q & floor_mask(floor_q))) begin
                clr        = floor_mask(floor_q);
                state_n    = S_DOOR;
                door_cnt_n = DW'(DOOR_TICKS);
            end else if (calls_q == '0) begin
                state_n = S_IDLE;
                dir_n   = DIR_IDLE;
            end else if (!car_full) begin
                if (up_ok && !(dir_q == DIR_DOWN && dn_ok)) begin
                    state_n = S_UP;
                    dir_n   = DIR_UP;
                end else begin
                    state_n = S_DOWN;
                    dir_n   = DIR_DOWN;
                end
            end
        end

        if (in_emerg || emerg_p) calls_n = '0;
        else                     calls_n = (calls_q | (call_sw & ~call_sw_q)) & ~clr;

        people_n = people_q;
        if (!in_emerg) begin
            if (add_p && !rem_p && people_q != MAXP)     people_n = people_q + PW'(1);
            else if (rem_p && !add_p && people_q != '0)  people_n = people_q - PW'(1);
        end
    end

    always_comb begin
        floor     = floor_q;
        dir       = dir_q;
        door_open = (state_q == S_DOOR);
        calls     = calls_q;
        people    = people_q;
        full      = (people_q == MAXP);
        emergency = (state_q == S_EMERG);
        fsm_state = state_q;
    end
endmodule
